// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch unit.
//   NOP_INSTR    : value returned for faulting fetches and used to clear memory
//   fault_e      : 2-bit fault code carried on rsp_fault
//   rsp_state_e  : occupancy of the one-entry response register
package imem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        FAULT_OK         = 2'b00,
        FAULT_MISALIGNED = 2'b01,
        FAULT_RANGE      = 2'b10
    } fault_e;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: DEPTH words of XLEN bits.
//   clk, reset         : clock, synchronous active-high clear of every word to NOP
//   wr_en/addr/data    : synchronous write port (program load)
//   rd_addr, rd_data   : combinational read port
module imem_array
    import imem_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [AW-1:0]   rd_addr,
    output logic [XLEN-1:0] rd_data
);

    logic [XLEN-1:0] mem [DEPTH];

    // NOTE: clearing a memory on reset forces it into flops instead of a RAM
    // macro; here it is intended, since a reset program image must read as NOP.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= XLEN'(NOP_INSTR);
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction fetch unit with a one-entry registered response.
//   clk, reset                     : clock, synchronous active-high reset
//   req_valid/req_ready/req_addr   : fetch request handshake, byte address
//   rsp_valid/rsp_ready            : response handshake
//   rsp_instr, rsp_fault           : fetched word and fault code (00/01/10)
//   ld_en/ld_addr/ld_data          : program-load write port (blocks fetch)
//   fetch_cnt                      : number of accepted fetches, wrapping
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter  int              XLEN      = 32,
    parameter  int              DEPTH     = 64,
    parameter  logic [XLEN-1:0] BASE_ADDR = '0,
    localparam int              AW        = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_instr,
    output logic [1:0]      rsp_fault,
    input  logic            ld_en,
    input  logic [AW-1:0]   ld_addr,
    input  logic [XLEN-1:0] ld_data,
    output logic [31:0]     fetch_cnt
);

    rsp_state_e      state_q, state_d;
    logic            accept;
    logic [XLEN-1:0] offset;
    logic [AW-1:0]   word_idx;
    logic [XLEN-1:0] mem_rd_data;
    logic [XLEN-1:0] fetch_instr;
    fault_e          fetch_fault;

    assign rsp_valid = (state_q == RSP_FULL);
    assign req_ready = !ld_en && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;

    // Addresses below BASE_ADDR wrap to huge offsets and land in the
    // out-of-range check. BASE_ADDR is word aligned, so offset[1:0] equals
    // req_addr[1:0].
    assign offset   = req_addr - BASE_ADDR;
    assign word_idx = offset[AW+1:2];

    imem_array #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (ld_en),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_addr (word_idx),
        .rd_data (mem_rd_data)
    );

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        fetch_fault = FAULT_OK;
        fetch_instr = mem_rd_data;
        if (offset[1:0] != 2'b00) begin
            fetch_fault = FAULT_MISALIGNED;
            fetch_instr = XLEN'(NOP_INSTR);
        end else if (offset[XLEN-1:AW+2] != '0) begin
            fetch_fault = FAULT_RANGE;
            fetch_instr = XLEN'(NOP_INSTR);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RSP_EMPTY: if (accept) state_d = RSP_FULL;
            RSP_FULL:  if (rsp_ready && !accept) state_d = RSP_EMPTY;
            default:   state_d = RSP_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RSP_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_instr <= XLEN'(NOP_INSTR);
            rsp_fault <= FAULT_OK;
            fetch_cnt <= '0;
        end else if (accept) begin
            rsp_instr <= fetch_instr;
            rsp_fault <= fetch_fault;
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_imem_fetch_unit.sv
module tb_imem_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, ld_en;
    logic [31:0] req_addr, rsp_instr, ld_data, fetch_cnt;
    logic [1:0]  rsp_fault;
    logic [5:0]  ld_addr;

    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_ld_en;
    logic [31:0] b_req_addr, b_rsp_instr, b_ld_data, b_fetch_cnt;
    logic [1:0]  b_rsp_fault;
    logic [5:0]  b_ld_addr;

    int checks   = 0;
    int failures = 0;

    imem_fetch_unit #(.XLEN(32), .DEPTH(64), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_fault(rsp_fault), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .fetch_cnt(fetch_cnt)
    );

    imem_fetch_unit #(.XLEN(32), .DEPTH(64), .BASE_ADDR(32'h0000_1000)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_instr(b_rsp_instr),
        .rsp_fault(b_rsp_fault), .ld_en(b_ld_en), .ld_addr(b_ld_addr),
        .ld_data(b_ld_data), .fetch_cnt(b_fetch_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_instr;
        logic [1:0]  exp_fault;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  fault;
    } rsp_t;

    vec_t        vecs [8];
    logic [31:0] model_mem [64];
    rsp_t        rsp_q [$];
    logic [31:0] exp_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    // Reference fetch computed directly from the address rules.
    function automatic rsp_t model_fetch(input logic [31:0] addr);
        rsp_t        r;
        logic [31:0] idx;
        idx = (addr - 32'h0000_0000) >> 2;
        if (addr[1:0] != 2'b00) begin
            r.instr = NOP; r.fault = 2'b01;
        end else if (idx >= 32'd64) begin
            r.instr = NOP; r.fault = 2'b10;
        end else begin
            r.instr = model_mem[idx[5:0]]; r.fault = 2'b00;
        end
        return r;
    endfunction

    initial begin
        reset = 1'b1;
        req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b1;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        b_req_valid = 1'b0; b_req_addr = '0; b_rsp_ready = 1'b1;
        b_ld_en = 1'b0; b_ld_addr = '0; b_ld_data = '0;

        // Reset: req_ready may assert but the request must not be taken.
        #1;
        check("reset_req_ready", req_ready, 1);
        tick(); tick();
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_instr", rsp_instr, NOP);
        check("reset_rsp_fault", rsp_fault, 0);
        check("reset_fetch_cnt", fetch_cnt, 0);
        reset = 1'b0;
        req_valid = 1'b0;

        load(6'd1, 32'h00A0_0093);
        load(6'd2, 32'h0020_0113);
        load(6'd0, 32'h0000_0513);
        load(6'd63, 32'hDEAD_BEEF);

        // Basic fetch, latency one cycle.
        req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        check("f4_valid", rsp_valid, 1);
        check("f4_instr", rsp_instr, 32'h00A0_0093);
        check("f4_fault", rsp_fault, 0);
        check("f4_cnt", fetch_cnt, 1);

        // Backpressure: response held, request blocked, then no-bubble refill.
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h8;
        #1;
        check("bp_req_ready", req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_instr", rsp_instr, 32'h00A0_0093);
            check("bp_hold_cnt", fetch_cnt, 1);
            check("bp_hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        check("b2b_valid", rsp_valid, 1);
        check("b2b_instr", rsp_instr, 32'h0020_0113);
        check("b2b_cnt", fetch_cnt, 2);
        tick();
        check("drain_valid", rsp_valid, 0);

        // Table of back-to-back fetches covering fault boundaries.
        vecs[0] = '{32'h0000_0006, NOP,          2'b01};
        vecs[1] = '{32'h0000_0100, NOP,          2'b10};
        vecs[2] = '{32'h0000_00FC, 32'hDEAD_BEEF, 2'b00};
        vecs[3] = '{32'h0000_0000, 32'h0000_0513, 2'b00};
        vecs[4] = '{32'hFFFF_FFFC, NOP,          2'b10};
        vecs[5] = '{32'h0000_0101, NOP,          2'b01};
        vecs[6] = '{32'h0000_0008, 32'h0020_0113, 2'b00};
        vecs[7] = '{32'h0000_0010, NOP,          2'b00};
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_addr = vecs[i].addr;
            tick();
            check($sformatf("vec%0d_valid", i), rsp_valid, 1);
            check($sformatf("vec%0d_instr", i), rsp_instr, vecs[i].exp_instr);
            check($sformatf("vec%0d_fault", i), rsp_fault, vecs[i].exp_fault);
            check($sformatf("vec%0d_cnt", i), fetch_cnt, 32'd3 + 32'(i));
        end
        req_valid = 1'b0;
        tick();

        // Load and fetch in the same cycle: load wins, fetch goes next cycle.
        ld_en = 1'b1; ld_addr = 6'd5; ld_data = 32'hCAFE_F00D;
        req_valid = 1'b1; req_addr = 32'h14;
        #1;
        check("ldfetch_ready", req_ready, 0);
        tick();
        check("ldfetch_no_accept", rsp_valid, 0);
        ld_en = 1'b0;
        #1;
        check("ldfetch_ready_after", req_ready, 1);
        tick();
        req_valid = 1'b0;
        check("ldfetch_instr", rsp_instr, 32'hCAFE_F00D);
        check("ldfetch_valid", rsp_valid, 1);

        // A later load leaves a held response untouched.
        rsp_ready = 1'b0;
        load(6'd5, 32'h1111_1111);
        check("held_after_load", rsp_instr, 32'hCAFE_F00D);

        // Reset while FULL discards the response and clears memory.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_full_valid", rsp_valid, 0);
        check("rst_full_cnt", fetch_cnt, 0);
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        check("rst_fetch_instr", rsp_instr, NOP);
        check("rst_fetch_fault", rsp_fault, 0);
        check("rst_fetch_cnt", fetch_cnt, 1);

        // Randomized phase against the queue-based reference.
        for (int i = 0; i < 64; i++) model_mem[i] = NOP;
        rsp_q.delete();
        rsp_q.push_back('{NOP, 2'b00});
        exp_cnt = 32'd1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [31:0] a;
            logic        exp_ready, acc;
            int          kind;
            kind = $urandom_range(0, 3);
            a = $urandom;
            case (kind)
                0: a = {24'd0, a[5:0], 2'b00};
                1: if (a[1:0] == 2'b00) a[0] = 1'b1;
                2: a[1:0] = 2'b00;
                default: ;
            endcase
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = a;
            rsp_ready = ($urandom_range(0, 2) != 0);
            ld_en     = ($urandom_range(0, 3) == 0);
            ld_addr   = 6'($urandom_range(0, 63));
            ld_data   = $urandom;
            #1;
            exp_ready = !ld_en && (rsp_q.size() == 0 || rsp_ready);
            check("rnd_req_ready", req_ready, exp_ready);
            acc = req_valid && exp_ready;
            tick();
            if (rsp_q.size() != 0 && rsp_ready) void'(rsp_q.pop_front());
            if (acc) begin
                rsp_q.push_back(model_fetch(req_addr));
                exp_cnt = exp_cnt + 32'd1;
            end
            if (ld_en) model_mem[ld_addr] = ld_data;
            check("rnd_rsp_valid", rsp_valid, rsp_q.size() != 0);
            check("rnd_fetch_cnt", fetch_cnt, exp_cnt);
            if (rsp_q.size() != 0) begin
                check("rnd_rsp_instr", rsp_instr, rsp_q[0].instr);
                check("rnd_rsp_fault", rsp_fault, rsp_q[0].fault);
            end
        end
        req_valid = 1'b0; ld_en = 1'b0; rsp_ready = 1'b1;
        tick();

        // Non-zero BASE_ADDR instance.
        b_ld_en = 1'b1; b_ld_addr = 6'd0; b_ld_data = 32'h1234_5678;
        tick();
        b_ld_en = 1'b0;
        b_req_valid = 1'b1; b_req_addr = 32'h0000_0FFC;
        tick();
        check("base_below_fault", b_rsp_fault, 2'b10);
        check("base_below_instr", b_rsp_instr, NOP);
        b_req_addr = 32'h0000_1000;
        tick();
        check("base_word0_fault", b_rsp_fault, 2'b00);
        check("base_word0_instr", b_rsp_instr, 32'h1234_5678);
        b_req_addr = 32'h0000_1004;
        tick();
        b_req_valid = 1'b0;
        check("base_word1_instr", b_rsp_instr, NOP);
        check("base_cnt", b_fetch_cnt, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
